// File: rtl/rr_mux_arbiter.sv
// Round-robin arbitrating N:1 mux with valid/ready on each input and a single registered output stage.
// Optional packet lock (channel stays granted while lock_in is set) enabled by RR_MUX_ARBITER_LOCK_EN.
module rr_mux_arbiter #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned NCH   = 4,
    localparam int unsigned SELW  = $clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH*WIDTH-1:0]  data_in,
    input  logic [NCH-1:0]        valid_in,
    output logic [NCH-1:0]        ready_out,
    output logic [WIDTH-1:0]      data_out,
    output logic                  valid_out,
    output logic [SELW-1:0]       sel_out,
`ifdef RR_MUX_ARBITER_LOCK_EN
    input  logic                  lock_in,
`endif
    input  logic                  ready_in
);

    logic [SELW-1:0]  last_grant;
    logic             load_en;
    logic [NCH-1:0]   req;
    logic             grant_vld;
    logic [SELW-1:0]  grant_idx;
    logic [SELW-1:0]  scan_idx;
    logic [WIDTH-1:0] grant_data;

    // Output register can take a new word when empty or being drained this cycle
    always_comb load_en = !valid_out || ready_in;

`ifdef RR_MUX_ARBITER_LOCK_EN
    logic lock_q;

    // While locked only the previously granted channel may compete
    always_comb begin
        req = valid_in;
        if (lock_q) begin
            req = valid_in & (NCH'(1) << last_grant);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= 1'b0;
        end else if (load_en && grant_vld) begin
            lock_q <= lock_in;
        end
    end
`else
    always_comb req = valid_in;
`endif

    // Scan from last_grant+1 with wrap; the last step revisits last_grant itself
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = last_grant;
        for (int k = 0; k < NCH; k++) begin
            scan_idx = (scan_idx == SELW'(NCH - 1)) ? '0 : scan_idx + SELW'(1);
            if (!grant_vld && req[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_idx == SELW'(i)) begin
                grant_data = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ready_out = '0;
        if (!rst && load_en && grant_vld) begin
            ready_out = NCH'(1) << grant_idx;
        end
    end

    // Output stage holds under backpressure; an empty load drops valid but keeps data/sel
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out  <= 1'b0;
            data_out   <= '0;
            sel_out    <= '0;
            last_grant <= SELW'(NCH - 1);
        end else if (load_en) begin
            if (grant_vld) begin
                data_out   <= grant_data;
                sel_out    <= grant_idx;
                valid_out  <= 1'b1;
                last_grant <= grant_idx;
            end else begin
                valid_out  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: directed scenarios followed by randomized traffic,
// checked against a round-robin reference model kept in the bench.
module tb_rr_mux_arbiter;

    localparam int unsigned W = 8;
    localparam int unsigned N = 4;
    localparam int unsigned S = $clog2(N);

    logic             clk = 1'b0;
    logic             rst;
    logic [N*W-1:0]   data_in;
    logic [N-1:0]     valid_in;
    logic [N-1:0]     ready_out;
    logic [W-1:0]     data_out;
    logic             valid_out;
    logic [S-1:0]     sel_out;
    logic             ready_in;
`ifdef RR_MUX_ARBITER_LOCK_EN
    logic             lock_in;
`endif

    rr_mux_arbiter #(.WIDTH(W), .NCH(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .sel_out   (sel_out),
`ifdef RR_MUX_ARBITER_LOCK_EN
        .lock_in   (lock_in),
`endif
        .ready_in  (ready_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        int           s;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: which channel won last, whether the output holds a word, lock status
    int   m_last    = N - 1;
    bit   m_valid   = 1'b0;
    bit   m_lock    = 1'b0;
    bit   started   = 1'b0;
    bit   was_rst   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Fair pick: first requester found walking upward from the last winner, modulo N
    function automatic int pick(input logic [N-1:0] v);
        if (m_lock) return v[m_last] ? m_last : -1;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic step(input bit r, input logic [N-1:0] v, input logic [N*W-1:0] d,
                        input bit rdy, input bit lk);
        int             g;
        bit             load;
        logic [N-1:0]   er;
        @(posedge clk);
        #1;
        if (started) begin
            chk("valid_out", 32'(valid_out), 32'(m_valid));
            if (m_valid && q.size() > 0) begin
                chk("hold_data", 32'(data_out), 32'(q[0].d));
                chk("hold_sel", 32'(sel_out), 32'(q[0].s));
            end
            if (was_rst) begin
                chk("rst_data", 32'(data_out), 32'h0);
                chk("rst_sel", 32'(sel_out), 32'h0);
            end
        end
`ifdef RR_MUX_ARBITER_LOCK_EN
        lock_in = lk;
`else
        lk = 1'b0;
`endif
        rst      = r;
        valid_in = v;
        data_in  = d;
        ready_in = rdy;
        #1;
        load = !m_valid || rdy;
        g    = pick(v);
        er   = (!r && load && g >= 0) ? (N'(1) << g) : '0;
        chk("ready_out", 32'(ready_out), 32'(er));
        if (r) begin
            m_valid = 1'b0;
            m_last  = N - 1;
            m_lock  = 1'b0;
            q.delete();
            was_rst = 1'b1;
            started = 1'b1;
        end else begin
            was_rst = 1'b0;
            if (load) begin
                if (g >= 0) begin
                    q.push_back('{d[g*W +: W], g});
                    m_valid = 1'b1;
                    m_last  = g;
                    m_lock  = lk;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    endtask

    // Monitor: every output handshake must deliver the oldest expected word
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && valid_out === 1'b1 && ready_in === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL drain_empty actual=word expected=none at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("drain_data", 32'(data_out), 32'(e.d));
                    chk("drain_sel", 32'(sel_out), 32'(e.s));
                end
            end
        end
    end

    initial begin
        logic [N*W-1:0] da;
        logic [N*W-1:0] dr;
        logic [N-1:0]   v;
        int             mode;
        rst = 1'b1; valid_in = '0; data_in = '0; ready_in = 1'b0;
`ifdef RR_MUX_ARBITER_LOCK_EN
        lock_in = 1'b0;
`endif
        for (int i = 0; i < N; i++) da[i*W +: W] = W'(8'hA0 + i);

        // Reset with every channel requesting, then full round robin
        step(1, '1, da, 1, 0);
        step(1, '1, da, 1, 0);
        for (int i = 0; i < 6; i++) step(0, '1, da, 1, 0);

        // Steer last_grant to 2, then sparse 3/1 alternation and a lone channel 2
        step(0, 4'b0100, da, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 4'b1010, da, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 4'b0100, da, 1, 0);

        // Backpressure: 0x55 from channel 1 stalls while channel 2 waits
        dr = da;
        dr[1*W +: W] = 8'h55;
        step(0, 4'b0010, dr, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 4'b0100, dr, 0, 0);
        step(0, 4'b0100, dr, 1, 0);
        step(0, 4'b0000, dr, 1, 0);

        // Reset while a word is stuck in the output register
        step(0, 4'b1000, da, 1, 0);
        step(0, 4'b1000, da, 0, 0);
        step(1, 4'b1000, da, 0, 0);
        step(0, '1, da, 1, 0);
        step(0, '0, da, 1, 0);

`ifdef RR_MUX_ARBITER_LOCK_EN
        step(1, '0, da, 1, 0);
        step(0, 4'b0100, da, 1, 1);
        step(0, '1, da, 1, 1);
        step(0, '1, da, 1, 0);
        step(0, '1, da, 1, 0);
        step(0, '0, da, 1, 0);
`endif

        // Randomized traffic in changing density regimes
        for (int i = 0; i < 3000; i++) begin
            mode = (i / 200) % 4;
            dr   = (N*W)'($urandom);
            case (mode)
                0:       v = N'($urandom) | N'($urandom);
                1:       v = N'($urandom);
                2:       v = N'(1) << $urandom_range(0, N - 1);
                default: v = N'($urandom) & N'($urandom);
            endcase
            step(($urandom_range(0, 299) == 0), v, dr, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0));
        end

        for (int i = 0; i < 4; i++) step(0, '0, da, 1, 0);
        chk("final_queue", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
